trng_entropy_buffer: RTL and testbench
======================================

Name: trng_entropy_buffer

Overview:
- Upstream feeder of the cipher top-level's TRNG port.
- Collects raw entropy bits from the on-chip noise source and runs a repetition-count health test on them.
- Packs healthy bits into 32-bit words and buffers the words in a small FIFO.
- Serves exactly one word per assertion of the consumer's trng_request, with a trng_ready pulse and a held trng_data.

Parameters:
DEPTH, 4, FIFO depth in 32-bit words (power of 2, at least 2).
RCT_LIMIT, 16, consecutive identical raw bits that declare a health failure (range 2..255).

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  asynchronous, active-high reset
raw_bit  in  1  entropy bit from the noise source, already synchronised into clk
raw_valid  in  1  raw_bit is valid this cycle; no backpressure exists, so bits not taken are lost
health_clr  in  1  single-cycle pulse that clears a health failure
trng_request  in  1  consumer request level; registered by the consumer
trng_ready  out  1  one-cycle pulse; trng_data holds a fresh word
trng_data  out  32  last popped word; held until the next pop
health_fail  out  1  sticky health-failure flag
fifo_level  out  $clog2(DEPTH+1)  number of words currently stored

Behaviour:
- Reset (asynchronous, active-high): trng_ready=0, trng_data=0, health_fail=0, fifo_level=0. Bit counter, run counter and last_bit are cleared, and arm is set to 1.
- Reset mid-word or mid-handshake: the partial word and the FIFO contents are discarded.
- Packing:
  - On raw_valid with health_fail=0, the word is shifted as {shift[30:0], raw_bit}, so the first bit received ends up in bit 31.
  - A 5-bit counter counts bits. When the 32nd bit arrives, the word is pushed into the FIFO in that same cycle and the counter wraps to 0.
  - The FIFO has 1-cycle latency: the pushed word counts in fifo_level from the following cycle.
- FIFO full: the completed word is dropped and packing continues. fifo_level stays at DEPTH, and the existing contents are unaffected.
- Repetition-count test, applied to every raw_valid bit while health_fail=0:
  - If raw_bit equals last_bit, run = run+1, saturating at RCT_LIMIT. Otherwise run = 1. last_bit is then updated.
  - The first bit after reset or after a clear starts with run = 1.
  - When run reaches RCT_LIMIT, health_fail=1 from the next cycle. The offending bit is not packed, the partial word is cleared, and the FIFO is flushed (fifo_level=0 next cycle).
  - If a 32nd bit triggers the failure, its word is not pushed.
- While health_fail=1: raw bits are ignored and no pops occur. trng_ready stays 0 and trng_data holds its previous value.
- health_clr: clears health_fail, the run counter and the bit counter on the next cycle. If a failure is detected in the same cycle as health_clr, the failure wins.
- Pop handshake:
  - A pop condition exists at a clock edge when trng_request=1, arm=1, fifo_level>0 (registered value) and health_fail=0.
  - On a pop, trng_data is loaded with the FIFO head, trng_ready=1 for exactly one cycle, and arm is cleared.
  - arm is set again in any cycle where trng_request=0. This gives at most one word per request assertion, because the consumer's registered request lingers for one cycle after it sees trng_ready.
  - A request held high continuously yields exactly one word.
  - If the request arrives while the FIFO is empty, arm stays set and the pop happens on the first edge with fifo_level>0. There is no fall-through from a same-cycle push.
- Simultaneous push and pop: both take effect and fifo_level is unchanged. Ordering is FIFO.
- trng_data is stable from the trng_ready pulse until the next pop; the consumer may sample it in any later cycle.

Decomposition:
- Package trng_pkg holds:
  - WORD_W=32;
  - the default DEPTH and RCT_LIMIT;
  - the level-width function $clog2(DEPTH+1).
- One sub-module, trng_word_fifo: synchronous FIFO with push, pop, flush, full, empty and level, using registered pointers with an extra wrap bit. It flushes on rst (asynchronous) and on a health failure (synchronous).
- The packer, the health test and the handshake arm stay in trng_entropy_buffer.

Test Plan:
- Reset check: assert rst mid-word with 20 bits loaded, release, then feed 32 more bits -> all outputs 0 during reset, and the first word holds only post-reset bits.
- Alternating bits 1,0,... for 32 bits, then request=1 for 3 cycles -> fifo_level=1 after the 32nd bit; one trng_ready pulse with trng_data=32'hAAAAAAAA; data held for 10 further cycles.
- Two words 32'hAAAAAAAA and 32'h55555555 queued; request high for 6 cycles, low for 1, high again -> exactly two trng_ready pulses, data AAAAAAAA then 55555555, fifo_level 2->1->0.
- Ten 1-bits, then 16 consecutive 0-bits with one word already queued -> health_fail=1 on the cycle after the 16th 0, fifo_level=0, request gets no ready. After health_clr plus 32 alternating bits, normal service resumes.
- DEPTH=4, five words 32'h33333333..32'h77777777 fed back-to-back -> fifo_level saturates at 4; pops return 33333333, 44444444, 55555555, 66666666, and 77777777 is dropped.
- With fifo_level=1, complete a second word in the same cycle as a pop -> fifo_level stays 1 and the next pop returns the second word.

Source files
------------

// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared widths, defaults and helpers for the TRNG entropy buffer
package trng_pkg;

    localparam int WORD_W        = 32;
    localparam int DEPTH_DEF     = 4;
    localparam int RCT_LIMIT_DEF = 16;

    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/trng_word_fifo.sv
// rtl/trng_word_fifo.sv - word FIFO with wrap-bit pointers, async reset and sync flush
module trng_word_fifo
    import trng_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = WORD_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      push,
    input  logic [W-1:0]              push_data,
    input  logic                      pop,
    output logic [W-1:0]              head,
    output logic                      full,
    output logic                      empty,
    output logic [level_w(DEPTH)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is never reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_comb begin
        diff  = wr_ptr - rd_ptr;
        head  = mem[rd_ptr[AW-1:0]];
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        level = LW'(diff);
    end

endmodule

// File: rtl/trng_entropy_buffer.sv
// rtl/trng_entropy_buffer.sv - health-tested entropy packer feeding a one-word-per-request TRNG port
module trng_entropy_buffer
    import trng_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int RCT_LIMIT = RCT_LIMIT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      raw_bit,
    input  logic                      raw_valid,
    input  logic                      health_clr,
    input  logic                      trng_request,
    output logic                      trng_ready,
    output logic [WORD_W-1:0]         trng_data,
    output logic                      health_fail,
    output logic [level_w(DEPTH)-1:0] fifo_level
);

    localparam logic [7:0] RCT_MAX = 8'(RCT_LIMIT);

    logic [4:0]        bit_cnt;
    logic [WORD_W-2:0] shift_q;
    logic [7:0]        run_cnt;
    logic [7:0]        run_next;
    logic              last_bit;
    logic              arm;
    logic              take;
    logic              fail_det;
    logic              word_done;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] word_next;
    logic [WORD_W-1:0] fifo_head;

    always_comb begin
        take      = raw_valid && !health_fail;
        word_next = {shift_q, raw_bit};
        // run_cnt == 0 marks "no previous bit" after reset or a clear
        run_next  = 8'd1;
        if (run_cnt != 8'd0 && raw_bit == last_bit)
            run_next = (run_cnt == RCT_MAX) ? RCT_MAX : run_cnt + 8'd1;
        fail_det  = take && (run_next == RCT_MAX);
        word_done = take && !fail_det && (bit_cnt == 5'd31);
        pop       = trng_request && arm && !fifo_empty && !health_fail;
        push      = word_done && (!fifo_full || pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            shift_q     <= '0;
            run_cnt     <= '0;
            last_bit    <= 1'b0;
            health_fail <= 1'b0;
        end else if (fail_det) begin
            health_fail <= 1'b1;
            bit_cnt     <= '0;
            shift_q     <= '0;
            run_cnt     <= run_next;
            last_bit    <= raw_bit;
        end else if (health_clr) begin
            health_fail <= 1'b0;
            bit_cnt     <= '0;
            run_cnt     <= '0;
        end else if (take) begin
            shift_q  <= word_next[WORD_W-2:0];
            bit_cnt  <= bit_cnt + 5'd1;
            run_cnt  <= run_next;
            last_bit <= raw_bit;
        end
    end

    // arm re-opens only once the consumer drops its request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm        <= 1'b1;
            trng_ready <= 1'b0;
            trng_data  <= '0;
        end else begin
            trng_ready <= pop;
            if (pop) trng_data <= fifo_head;
            if (!trng_request) arm <= 1'b1;
            else if (pop)      arm <= 1'b0;
        end
    end

    trng_word_fifo #(
        .DEPTH (DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (fail_det),
        .push      (push),
        .push_data (word_next),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_trng_entropy_buffer.sv
// tb/tb_trng_entropy_buffer.sv - directed self-checking bench for trng_entropy_buffer
module tb_trng_entropy_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        raw_bit = 1'b0;
    logic        raw_valid = 1'b0;
    logic        health_clr = 1'b0;
    logic        trng_request = 1'b0;
    logic        trng_ready;
    logic [31:0] trng_data;
    logic        health_fail;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    trng_entropy_buffer #(.DEPTH(4), .RCT_LIMIT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .raw_bit      (raw_bit),
        .raw_valid    (raw_valid),
        .health_clr   (health_clr),
        .trng_request (trng_request),
        .trng_ready   (trng_ready),
        .trng_data    (trng_data),
        .health_fail  (health_fail),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        raw_bit   = b;
        raw_valid = 1'b1;
        tick();
        raw_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic test_reset;
        tick();
        tick();
        checks++;
        if (trng_ready !== 1'b0 || trng_data !== 32'h0 || health_fail !== 1'b0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL reset_init: ready=%b data=%h hf=%b level=%0d, want 0/0/0/0", trng_ready, trng_data, health_fail, fifo_level);
        end
        rst = 1'b0;
        send_word(32'hAAAAAAAA);
        trng_request = 1'b1;
        tick();
        trng_request = 1'b0;
        tick();
        send_word(32'hAAAAAAAA);
        for (int i = 0; i < 20; i++) send_bit((i % 4) < 2);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (trng_ready !== 1'b0 || trng_data !== 32'h0 || health_fail !== 1'b0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b data=%h hf=%b level=%0d, want 0/0/0/0", trng_ready, trng_data, health_fail, fifo_level);
        end
        tick();
        tick();
        rst = 1'b0;
        send_word(32'h12345678);
        checks++;
        if (fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL reset_level: got %0d want 1", fifo_level);
        end
        trng_request = 1'b1;
        tick();
        checks++;
        if (trng_ready !== 1'b1 || trng_data !== 32'h12345678) begin
            errors++;
            $display("FAIL reset_word: ready=%b data=%h want 1/12345678", trng_ready, trng_data);
        end
        trng_request = 1'b0;
        tick();
    endtask

    task automatic test_single;
        int pulses;
        pulses = 0;
        send_word(32'hAAAAAAAA);
        checks++;
        if (fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL single_level: got %0d want 1", fifo_level);
        end
        trng_request = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (trng_ready) pulses++;
            if (c == 0) begin
                checks++;
                if (trng_ready !== 1'b1 || trng_data !== 32'hAAAAAAAA) begin
                    errors++;
                    $display("FAIL single_pop: ready=%b data=%h want 1/aaaaaaaa", trng_ready, trng_data);
                end
            end
        end
        trng_request = 1'b0;
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL single_pulses: got %0d want 1", pulses);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (trng_ready !== 1'b0 || trng_data !== 32'hAAAAAAAA) begin
                errors++;
                $display("FAIL single_hold: cycle %0d ready=%b data=%h want 0/aaaaaaaa", c, trng_ready, trng_data);
            end
        end
    endtask

    task automatic test_back_to_back;
        int pulses;
        pulses = 0;
        send_word(32'hAAAAAAAA);
        send_word(32'h55555555);
        checks++;
        if (fifo_level !== 3'd2) begin
            errors++;
            $display("FAIL b2b_level2: got %0d want 2", fifo_level);
        end
        trng_request = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (trng_ready) pulses++;
            if (c == 0) begin
                checks++;
                if (trng_ready !== 1'b1 || trng_data !== 32'hAAAAAAAA || fifo_level !== 3'd1) begin
                    errors++;
                    $display("FAIL b2b_first: ready=%b data=%h level=%0d want 1/aaaaaaaa/1", trng_ready, trng_data, fifo_level);
                end
            end
        end
        checks++;
        if (pulses != 1 || fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL b2b_held: pulses=%0d level=%0d want 1/1", pulses, fifo_level);
        end
        trng_request = 1'b0;
        tick();
        trng_request = 1'b1;
        tick();
        checks++;
        if (trng_ready !== 1'b1 || trng_data !== 32'h55555555 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL b2b_second: ready=%b data=%h level=%0d want 1/55555555/0", trng_ready, trng_data, fifo_level);
        end
        trng_request = 1'b0;
        tick();
    endtask

    task automatic test_health;
        int pulses;
        pulses = 0;
        send_word(32'hAAAAAAAA);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        for (int i = 0; i < 15; i++) send_bit(1'b0);
        checks++;
        if (health_fail !== 1'b0 || fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL health_15: hf=%b level=%0d want 0/1", health_fail, fifo_level);
        end
        send_bit(1'b0);
        checks++;
        if (health_fail !== 1'b1 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL health_16: hf=%b level=%0d want 1/0", health_fail, fifo_level);
        end
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        trng_request = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (trng_ready) pulses++;
        end
        trng_request = 1'b0;
        tick();
        checks++;
        if (pulses != 0 || trng_data !== 32'h55555555 || health_fail !== 1'b1) begin
            errors++;
            $display("FAIL health_block: pulses=%0d data=%h hf=%b want 0/55555555/1", pulses, trng_data, health_fail);
        end
        health_clr = 1'b1;
        tick();
        health_clr = 1'b0;
        checks++;
        if (health_fail !== 1'b0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL health_clr: hf=%b level=%0d want 0/0", health_fail, fifo_level);
        end
        send_word(32'hAAAAAAAA);
        trng_request = 1'b1;
        tick();
        checks++;
        if (trng_ready !== 1'b1 || trng_data !== 32'hAAAAAAAA) begin
            errors++;
            $display("FAIL health_resume: ready=%b data=%h want 1/aaaaaaaa", trng_ready, trng_data);
        end
        trng_request = 1'b0;
        tick();
    endtask

    task automatic test_full;
        logic [31:0] words [5];
        logic [2:0]  want_lvl;
        int          pulses;
        words = '{32'h33333333, 32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};
        for (int i = 0; i < 5; i++) begin
            send_word(words[i]);
            want_lvl = (i < 4) ? 3'(i + 1) : 3'd4;
            checks++;
            if (fifo_level !== want_lvl) begin
                errors++;
                $display("FAIL full_level%0d: got %0d want %0d", i, fifo_level, want_lvl);
            end
        end
        for (int i = 0; i < 4; i++) begin
            trng_request = 1'b1;
            tick();
            checks++;
            if (trng_ready !== 1'b1 || trng_data !== words[i]) begin
                errors++;
                $display("FAIL full_pop%0d: ready=%b data=%h want 1/%h", i, trng_ready, trng_data, words[i]);
            end
            trng_request = 1'b0;
            tick();
        end
        pulses = 0;
        trng_request = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (trng_ready) pulses++;
        end
        trng_request = 1'b0;
        tick();
        checks++;
        if (pulses != 0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL full_dropped: pulses=%0d level=%0d want 0/0", pulses, fifo_level);
        end
    endtask

    task automatic test_simul;
        logic [31:0] w;
        w = 32'h55555555;
        send_word(32'hAAAAAAAA);
        for (int i = 31; i >= 1; i--) send_bit(w[i]);
        raw_bit      = w[0];
        raw_valid    = 1'b1;
        trng_request = 1'b1;
        tick();
        raw_valid    = 1'b0;
        trng_request = 1'b0;
        checks++;
        if (trng_ready !== 1'b1 || trng_data !== 32'hAAAAAAAA || fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL simul_pop: ready=%b data=%h level=%0d want 1/aaaaaaaa/1", trng_ready, trng_data, fifo_level);
        end
        tick();
        trng_request = 1'b1;
        tick();
        checks++;
        if (trng_ready !== 1'b1 || trng_data !== 32'h55555555 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL simul_next: ready=%b data=%h level=%0d want 1/55555555/0", trng_ready, trng_data, fifo_level);
        end
        trng_request = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_health();
        test_full();
        test_simul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
